// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback handshake between the pipeline and the register scoreboard.
// The slave side is the scoreboard; the master side is decode/writeback control.
interface regfile_scoreboard_if #(
    parameter int DEPTH = 4
);
    logic [31:0]              issue_inst;
    logic                     issue_valid;
    logic                     wb_valid;
    logic                     stall;
    logic [4:0]               wb_rd;
    logic [31:0]              busy;
    logic [$clog2(DEPTH):0]   pending;
    logic                     err;

    modport master (
        output issue_inst, issue_valid, wb_valid,
        input  stall, wb_rd, busy, pending, err
    );
    modport slave (
        input  issue_inst, issue_valid, wb_valid,
        output stall, wb_rd, busy, pending, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// In-order write scoreboard: tracks outstanding register writes, stalls decode on
// RAW hazards or a full write queue, and retires writes oldest-first.
`ifndef OPC_LUI
`define OPC_LUI       7'b0110111
`define OPC_AUIPC     7'b0010111
`define OPC_JAL       7'b1101111
`define OPC_JALR      7'b1100111
`define OPC_BRANCH    7'b1100011
`define OPC_STORE     7'b0100011
`define OPC_LOAD      7'b0000011
`define OPC_ARI_RTYPE 7'b0110011
`define OPC_ARI_ITYPE 7'b0010011
`define OPC_NOOP      7'b0000000
`endif

module regfile_scoreboard #(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    regfile_scoreboard_if.slave  sb
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Per-register counters are never narrower than 3 bits.
    localparam int CW = (PW < 3) ? 3 : PW;

    logic [CW-1:0] cnt [32];
    logic [4:0]    fifo [DEPTH];
    logic [AW-1:0] head, tail;
    logic [PW-1:0] pend;
    logic          err_q;

    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic        has_rd, has_rs1, has_rs2;
    logic        empty, full, raw_hit, stall_c, fire, pop;
    logic [4:0]  head_rd;
    logic [31:0] busy_v, busy_eff, inc, dec;

    assign opc = sb.issue_inst[6:0];
    assign rd  = sb.issue_inst[11:7];
    assign rs1 = sb.issue_inst[19:15];
    assign rs2 = sb.issue_inst[24:20];

    assign has_rd  = (opc != `OPC_BRANCH) && (opc != `OPC_STORE) && (opc != `OPC_NOOP) && (rd != 5'd0);
    assign has_rs1 = (opc != `OPC_LUI) && (opc != `OPC_AUIPC) && (opc != `OPC_JAL) && (opc != `OPC_NOOP);
    assign has_rs2 = (opc == `OPC_BRANCH) || (opc == `OPC_STORE) || (opc == `OPC_ARI_RTYPE);

    assign empty   = (pend == PW'(0));
    assign full    = (pend == PW'(DEPTH));
    assign head_rd = empty ? 5'd0 : fifo[head];
    assign pop     = sb.wb_valid && !empty;

    // A register whose last outstanding write retires this cycle is readable now.
    always_comb begin
        busy_v   = '0;
        busy_eff = '0;
        for (int r = 1; r < 32; r++) begin
            busy_v[r]   = (cnt[r] != CW'(0));
            busy_eff[r] = busy_v[r] &&
                          !(pop && (head_rd == 5'(r)) && (cnt[r] == CW'(1)));
        end
    end

    assign raw_hit = sb.issue_valid &&
                     ((has_rs1 && (rs1 != 5'd0) && busy_eff[rs1]) ||
                      (has_rs2 && (rs2 != 5'd0) && busy_eff[rs2]));
    // Full stalls regardless of a same-cycle pop.
    assign stall_c = sb.issue_valid && (raw_hit || full);
    assign fire    = sb.issue_valid && !stall_c && has_rd;

    always_comb begin
        inc = '0;
        dec = '0;
        if (fire) inc[rd] = 1'b1;
        if (pop)  dec[head_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            pend  <= '0;
            err_q <= 1'b0;
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            if (fire) begin
                fifo[tail] <= rd;
                tail       <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            pend <= pend + PW'(fire) - PW'(pop);
            for (int r = 0; r < 32; r++) begin
                if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + CW'(1);
                else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - CW'(1);
            end
            if (sb.wb_valid && empty) err_q <= 1'b1;
        end
    end

    assign sb.stall   = stall_c;
    assign sb.wb_rd   = head_rd;
    assign sb.busy    = busy_v;
    assign sb.pending = pend;
    assign sb.err     = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-encoded RV32I instructions.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] ADDI_X5   = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] ADD_X6    = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] ADDI_X1   = 32'h0010_0093;
    localparam logic [31:0] ADDI_X2   = 32'h0010_0113;
    localparam logic [31:0] ADDI_X3   = 32'h0010_0193;
    localparam logic [31:0] ADDI_X4   = 32'h0010_0213;
    localparam logic [31:0] SW_X7     = 32'h0074_2023; // sw x7,0(x8)
    localparam logic [31:0] ADDI_X9   = 32'h0010_0493; // addi x9,x0,1
    localparam logic [31:0] ADD_X1_X9 = 32'h0004_80B3; // add x1,x9,x0
    localparam logic [31:0] ADDI_X0   = 32'h0010_8013; // addi x0,x1,1
    localparam logic [31:0] LUI_X0    = 32'h0000_1037; // lui x0,1

    regfile_scoreboard_if #(.DEPTH(4)) sb ();
    regfile_scoreboard #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .sb(sb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; settle before any comparison.
    task automatic drive(input logic [31:0] inst, input logic iv, input logic wv);
        sb.issue_inst  = inst;
        sb.issue_valid = iv;
        sb.wb_valid    = wv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        sb.issue_inst = '0; sb.issue_valid = 1'b0; sb.wb_valid = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_busy",    sb.busy, 32'h0);
        chk("rst_pending", 32'(sb.pending), 32'd0);
        chk("rst_wb_rd",   32'(sb.wb_rd), 32'd0);
        chk("rst_err",     32'(sb.err), 32'd0);
        chk("rst_stall",   32'(sb.stall), 32'd0);

        // RAW on x5, then same-cycle writeback bypass
        drive(ADDI_X5, 1'b1, 1'b0);
        chk("raw_c1_stall", 32'(sb.stall), 32'd0);
        tick();
        drive(ADD_X6, 1'b1, 1'b0);
        chk("raw_c2_stall", 32'(sb.stall), 32'd1);
        chk("raw_c2_busy5", 32'(sb.busy[5]), 32'd1);
        chk("raw_c2_pend",  32'(sb.pending), 32'd1);
        chk("raw_c2_wbrd",  32'(sb.wb_rd), 32'd5);
        tick();
        drive(ADD_X6, 1'b1, 1'b1);
        chk("byp_stall", 32'(sb.stall), 32'd0);
        tick();
        drive(32'h0, 1'b0, 1'b0);
        chk("byp_busy5", 32'(sb.busy[5]), 32'd0);
        chk("byp_busy6", 32'(sb.busy[6]), 32'd1);
        chk("byp_wbrd",  32'(sb.wb_rd), 32'd6);
        chk("byp_pend",  32'(sb.pending), 32'd1);
        drive(32'h0, 1'b0, 1'b1);
        tick();
        chk("byp_drain", 32'(sb.pending), 32'd0);

        // Fill the queue; a full queue stalls even a store with a pop
        drive(ADDI_X1, 1'b1, 1'b0); chk("fill1", 32'(sb.stall), 32'd0); tick();
        drive(ADDI_X2, 1'b1, 1'b0); chk("fill2", 32'(sb.stall), 32'd0); tick();
        drive(ADDI_X3, 1'b1, 1'b0); chk("fill3", 32'(sb.stall), 32'd0); tick();
        drive(ADDI_X4, 1'b1, 1'b0); chk("fill4", 32'(sb.stall), 32'd0); tick();
        drive(SW_X7, 1'b1, 1'b0);
        chk("full_pend",  32'(sb.pending), 32'd4);
        chk("full_stall", 32'(sb.stall), 32'd1);
        chk("full_busy",  sb.busy, 32'h0000_001E);
        drive(SW_X7, 1'b1, 1'b1);
        chk("full_pop_stall", 32'(sb.stall), 32'd1);
        tick();
        drive(SW_X7, 1'b1, 1'b0);
        chk("after_pop_pend",  32'(sb.pending), 32'd3);
        chk("after_pop_wbrd",  32'(sb.wb_rd), 32'd2);
        chk("after_pop_stall", 32'(sb.stall), 32'd0);
        tick();
        chk("store_nopush", 32'(sb.pending), 32'd3);
        drive(32'h0, 1'b0, 1'b1);
        tick(); tick();
        chk("wrap_wbrd", 32'(sb.wb_rd), 32'd4);
        tick();
        chk("drain2", 32'(sb.pending), 32'd0);
        chk("drain2_busy", sb.busy, 32'h0);

        // Two writes to x9: bypass only when the last one retires
        drive(ADDI_X9, 1'b1, 1'b0); tick();
        drive(ADDI_X9, 1'b1, 1'b0); tick();
        drive(ADD_X1_X9, 1'b1, 1'b1);
        chk("x9_cnt2_stall", 32'(sb.stall), 32'd1);
        tick();
        drive(ADD_X1_X9, 1'b1, 1'b0);
        chk("x9_pend",  32'(sb.pending), 32'd1);
        chk("x9_busy",  32'(sb.busy[9]), 32'd1);
        chk("x9_nobyp_stall", 32'(sb.stall), 32'd1);
        drive(ADD_X1_X9, 1'b1, 1'b1);
        chk("x9_byp_stall", 32'(sb.stall), 32'd0);
        tick();
        drive(32'h0, 1'b0, 1'b0);
        chk("x9_push_pop_pend", 32'(sb.pending), 32'd1);
        chk("x9_push_pop_busy", sb.busy, 32'h0000_0002);
        chk("x9_push_pop_wbrd", 32'(sb.wb_rd), 32'd1);

        // Reset discards in-flight writes even with an issue pending
        drive(ADDI_X5, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0);
        chk("rstprio_pend", 32'(sb.pending), 32'd0);
        chk("rstprio_busy", sb.busy, 32'h0);

        // Spurious writeback sets sticky err
        drive(32'h0, 1'b0, 1'b1);
        tick();
        drive(32'h0, 1'b0, 1'b0);
        chk("err_set",  32'(sb.err), 32'd1);
        chk("err_pend", 32'(sb.pending), 32'd0);
        tick();
        chk("err_sticky", 32'(sb.err), 32'd1);
        do_reset();
        chk("err_clr",  32'(sb.err), 32'd0);
        chk("err_busy", sb.busy, 32'h0);

        // rd = x0 never pushes
        drive(ADDI_X0, 1'b1, 1'b0);
        chk("x0_addi_stall", 32'(sb.stall), 32'd0);
        tick();
        drive(LUI_X0, 1'b1, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0);
        chk("x0_pend",  32'(sb.pending), 32'd0);
        chk("x0_busy0", 32'(sb.busy[0]), 32'd0);
        chk("x0_busy",  sb.busy, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of outstanding register writes tracked (power of 2, 2..16).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port issue_inst  input  32  instruction presented at decode (stage 2).
REQ-005 The block SHALL have port issue_valid  input  1  issue_inst is a real instruction this cycle.
REQ-006 The block SHALL have port wb_valid  input  1  the oldest outstanding write retires this cycle.
REQ-007 The block SHALL have port stall  output  1  decode must hold issue_inst; no issue this cycle.
REQ-008 The block SHALL have port wb_rd  output  5  destination register of the oldest outstanding write (0 when empty).
REQ-009 The block SHALL have port busy  output  32  bit r set while register r has one or more outstanding writes; bit 0 always 0.
REQ-010 The block SHALL have port pending  output  log2(DEPTH)+1  number of outstanding writes.
REQ-011 The block SHALL have port err  output  1  sticky flag: wb_valid seen with no outstanding write.

Function
REQ-012 Decoding SHALL use the `OPC_* macros from Opcode.vh: has_rd = opcode not BRANCH, STORE, NOOP, and rd = inst[11:7] nonzero; has_rs1 = opcode not LUI, AUIPC, JAL, NOOP; has_rs2 = opcode BRANCH, STORE or ARI_RTYPE.
REQ-013 rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
REQ-014 The block SHALL keep a per-register 3-bit-min outstanding-write counter cnt[r] (width log2(DEPTH)+1) and an in-order FIFO of DEPTH 5-bit rd entries; busy[r] = (cnt[r] != 0).
REQ-015 raw_hit SHALL be asserted when issue_valid and ((has_rs1 and rs1 != 0 and busy_eff[rs1]) or (has_rs2 and rs2 != 0 and busy_eff[rs2])).
REQ-016 busy_eff[r] SHALL equal busy[r] except it is 0 when wb_valid, FIFO non-empty, wb_rd == r and cnt[r] == 1 (same-cycle writeback bypass).
REQ-017 stall SHALL be combinational: issue_valid and (raw_hit or FIFO full); a full FIFO stalls even when wb_valid pops in the same cycle.
REQ-018 issue_fire = issue_valid and not stall and has_rd; on issue_fire the block SHALL push rd to the FIFO tail and increment cnt[rd].
REQ-019 pop = wb_valid and FIFO non-empty; on pop the block SHALL advance the head and decrement cnt[wb_rd].
REQ-020 Simultaneous push and pop to the same register SHALL leave cnt unchanged; pending changes by push minus pop.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by pending, not by pointer equality.
REQ-022 wb_valid with empty FIFO SHALL change no state except setting err to 1 until reset.
REQ-023 wb_rd, busy, pending SHALL be registered-state-derived only (no combinational path from issue_* or wb_valid).
REQ-024 Issue of an instruction without rd (store, branch, rd = x0) SHALL never stall on FIFO full unless raw_hit or full per REQ-017 (full still stalls, uniformly).

Reset
REQ-025 With rst high at a clock edge, all cnt, FIFO pointers, pending, err SHALL become 0; busy = 0, wb_rd = 0, stall = 0 when issue_valid = 0.
REQ-026 Reset SHALL take priority over simultaneous push/pop; outstanding writes mid-flight are discarded.

Verification
REQ-027 Issue addi x5,x0,1 then add x6,x5,x5 next cycle with wb_valid = 0 -> cycle 2 stall = 1, busy[5] = 1, pending = 1, wb_rd = 5.
REQ-028 Same as REQ-027 but wb_valid = 1 in cycle 2 -> stall = 0, cycle 3 busy[5] = 0, busy[6] = 1, wb_rd = 6.
REQ-029 Issue four writes x1..x4 (DEPTH = 4), then sw x7,0(x8) -> stall = 1 with pending = 4; one wb_valid pop still stalls that cycle, next cycle stall = 0.
REQ-030 Issue two writes to x9, then one pop -> busy[9] = 1, cnt path: pending = 1; add x1,x9,x0 with second pop same cycle -> stall = 0.
REQ-031 wb_valid with pending = 0 -> err = 1, pending stays 0; assert rst -> err = 0, all busy = 0.
REQ-032 addi x0,x1,1 and lui x0 issue -> no push, pending unchanged, busy[0] = 0.
